// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   - WORD_W / BYTE_W / LEN_W : word, byte and length-field widths
//   - state_t                 : loader FSM state encoding
//   - accepts_byte()          : states in which the loader offers in_ready
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds the S_CHK state.
package imem_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int LEN_W  = 16;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_CHK    = 3'd5,
    S_DONE   = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd6
  } state_t;
`endif

  // States that take a byte from the stream.
  function automatic logic accepts_byte(input state_t s);
    logic r;
    r = (s == S_LEN_LO) || (s == S_LEN_HI) || (s == S_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
    r = r || (s == S_CHK);
`endif
    return r;
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// imem_byte_packer: assembles little-endian bytes into a 32-bit word.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : returns the byte index to lane 0
//   load      : byte_in is consumed this cycle
//   byte_in   : incoming byte
//   word      : assembled word including the byte being loaded this cycle,
//               so the caller can capture a complete word on the 4th load
//   last      : the next load fills the top lane (completes the word)
module imem_byte_packer
  import imem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word,
  output logic              last
);

  logic [WORD_W-1:0] lanes;
  logic [1:0]        idx;

  always_comb begin
    word = lanes;
    if (load) word[{idx, 3'b000} +: BYTE_W] = byte_in;
  end

  assign last = (idx == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lanes <= '0;
      idx   <= '0;
    end else if (clear) begin
      idx   <= '0;
    end else if (load) begin
      lanes <= word;
      idx   <= idx + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory from a length-prefixed byte stream.
// Stream: count[7:0], count[15:8], then 4*count data bytes (LSB first per word),
// then one XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   start      : pulse, arms the loader from IDLE or DONE
//   in_valid / in_byte / in_ready : byte stream; transfer when valid && ready
//   mem_we / mem_addr / mem_wdata : single-cycle word write into imem
//   busy, done, err : status; done and err hold until next start or reset
//   fsm_state  : current FSM state (debug visibility)
// Handshake: a byte moves on a rising edge where in_valid && in_ready; the
// source holds in_byte stable while in_valid is high and in_ready is low.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_byte,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output state_t            fsm_state
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_AFTER = S_CHK;
`else
  localparam state_t S_AFTER = S_DONE;
`endif

  state_t            state, state_n;
  logic [LEN_W-1:0]  count, word_idx, cnt_new;
  logic              xfer, over_max, zero_cnt;
  logic              pk_clear, pk_load, pk_last;
  logic [WORD_W-1:0] pk_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] chk;
`endif

  assign fsm_state = state;
  assign xfer      = in_valid && in_ready;
  // Full count as it will be once the high length byte is accepted.
  assign cnt_new   = {in_byte, count[7:0]};
  assign over_max  = 32'(cnt_new) > MAX_WORDS;
  assign zero_cnt  = (cnt_new == '0);
  // The packer only runs while words are being streamed.
  assign pk_clear  = (state != S_DATA) && (state != S_WRITE);
  assign pk_load   = (state == S_DATA) && xfer;

  imem_byte_packer u_packer (
    .clk     (clk),
    .rst     (rst),
    .clear   (pk_clear),
    .load    (pk_load),
    .byte_in (in_byte),
    .word    (pk_word),
    .last    (pk_last)
  );

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_n = S_LEN_LO;
      S_LEN_LO:       if (xfer) state_n = S_LEN_HI;
      S_LEN_HI: begin
        if (xfer) begin
          if (zero_cnt)      state_n = S_AFTER;
          else if (over_max) state_n = S_DONE;
          else               state_n = S_DATA;
        end
      end
      S_DATA:  if (xfer && pk_last) state_n = S_WRITE;
      S_WRITE: state_n = (word_idx + 16'd1 == count) ? S_AFTER : S_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK:   if (xfer) state_n = S_DONE;
`endif
      default: state_n = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with
  // the state register itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      count     <= '0;
      word_idx  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk       <= '0;
`endif
    end else begin
      state    <= state_n;
      in_ready <= accepts_byte(state_n);
      busy     <= (state_n != S_IDLE) && (state_n != S_DONE);
      done     <= (state_n == S_DONE);
      mem_we   <= (state_n == S_WRITE);
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            err <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk <= '0;
`endif
          end
        end
        S_LEN_LO: if (xfer) count[7:0] <= in_byte;
        S_LEN_HI: begin
          if (xfer) begin
            count[15:8] <= in_byte;
            word_idx    <= '0;
            if (over_max) err <= 1'b1;
          end
        end
        S_DATA: begin
          if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk <= chk ^ in_byte;
`endif
            // Capture address and word on the 4th byte so they are valid in
            // the WRITE cycle alongside mem_we.
            if (pk_last) begin
              mem_addr  <= BASE + ADDR_W'(word_idx);
              mem_wdata <= pk_word;
            end
          end
        end
        S_WRITE: word_idx <= word_idx + 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK: if (xfer) err <= (in_byte != chk);
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  import imem_pkg::*;

  localparam int unsigned MAXW = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = 8'h00;

  logic        in_ready0, mem_we0, busy0, done0, err0;
  logic [31:0] mem_addr0, mem_wdata0;
  state_t      st0;
  logic        in_ready1, mem_we1, busy1, done1, err1;
  logic [31:0] mem_addr1, mem_wdata1;
  state_t      st1;

  int checks = 0;
  int failures = 0;
  int nwr = 0;
  bit prev_we = 1'b0;

  logic [31:0] exp_q[$];
  int          exp_i[$];
  logic [7:0]  data_b[$];

  // Two loaders see the same stream; they differ only in base address.
  imem_loader #(.ADDR_W(32), .BASE_ADDR(0), .MAX_WORDS(MAXW)) dut0 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready0), .mem_we(mem_we0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .busy(busy0), .done(done0), .err(err0), .fsm_state(st0));

  imem_loader #(.ADDR_W(32), .BASE_ADDR(16), .MAX_WORDS(MAXW)) dut1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .busy(busy1), .done(done1), .err(err1), .fsm_state(st1));

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- write scoreboard ----------------
  always @(negedge clk) begin
    logic [31:0] e;
    int          i;
    if (mem_we0 || mem_we1) begin
      nwr++;
      checks++;
      if (mem_we0 !== mem_we1 || prev_we) begin
        failures++;
        $display("FAIL write_strobe we0=%0b we1=%0b prev=%0b required single-cycle matched strobes",
                 mem_we0, mem_we1, prev_we);
      end
      checks++;
      if (in_ready0 !== 1'b0 || in_ready1 !== 1'b0) begin
        failures++;
        $display("FAIL ready_in_write in_ready0=%0b in_ready1=%0b required 0", in_ready0, in_ready1);
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr0=%0d data0=%h required no write", mem_addr0, mem_wdata0);
      end else begin
        e = exp_q.pop_front();
        i = exp_i.pop_front();
        if (mem_addr0 !== 32'(i) || mem_wdata0 !== e ||
            mem_addr1 !== 32'(i + 16) || mem_wdata1 !== e) begin
          failures++;
          $display("FAIL write_data got %h@%0d / %h@%0d required %h@%0d / %h@%0d",
                   mem_wdata0, mem_addr0, mem_wdata1, mem_addr1, e, i, e, i + 16);
        end
      end
    end
    prev_we = mem_we0;
  end

  // ---------------- reference model ----------------
  // Expected writes: word i is data bytes 4i..4i+3, first byte least significant.
  task automatic model_push(input int unsigned cnt);
    for (int i = 0; i < int'(cnt); i++) begin
      exp_q.push_back({data_b[4*i+3], data_b[4*i+2], data_b[4*i+1], data_b[4*i]});
      exp_i.push_back(i);
    end
  endtask

  function automatic logic [7:0] model_xor();
    logic [7:0] x = 8'h00;
    foreach (data_b[k]) x ^= data_b[k];
    return x;
  endfunction

  // ---------------- drivers ----------------
  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gapmax);
    bit rdy;
    bit ok = 1'b0;
    int g;
    in_valid = 1'b1;
    in_byte  = b;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      rdy = in_ready0;
      @(posedge clk); #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL byte_timeout byte=%h not accepted within 100 cycles", b);
    end
    g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
    if (g > 0) begin
      in_valid = 1'b0;
      in_byte  = 8'h00;
      repeat (g) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      if (done0 === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL done_timeout done0=%0b required 1 within 100 cycles", done0);
    end
  endtask

  // Full load of the stream in data_b with the given count.
  task automatic load(input int unsigned cnt, input int gapmax, input logic [7:0] chk_byte);
    logic [15:0] c16;
    c16 = cnt[15:0];
    pulse_start();
    send_byte(c16[7:0], gapmax);
    send_byte(c16[15:8], gapmax);
    foreach (data_b[k]) send_byte(data_b[k], gapmax);
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (cnt <= MAXW) send_byte(chk_byte, gapmax);
`else
    if (chk_byte != chk_byte) $display("unused");
`endif
    in_valid = 1'b0;
    in_byte  = 8'h00;
    wait_done();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(posedge clk); #1;
    checks++;
    if (in_ready0 !== 0 || mem_we0 !== 0 || mem_addr0 !== 0 || mem_wdata0 !== 0 ||
        busy0 !== 0 || done0 !== 0 || err0 !== 0) begin
      failures++;
      $display("FAIL reset_outputs0 rdy=%0b we=%0b addr=%h data=%h busy=%0b done=%0b err=%0b required all 0",
               in_ready0, mem_we0, mem_addr0, mem_wdata0, busy0, done0, err0);
    end
    checks++;
    if (in_ready1 !== 0 || mem_we1 !== 0 || mem_addr1 !== 0 || mem_wdata1 !== 0 ||
        busy1 !== 0 || done1 !== 0 || err1 !== 0) begin
      failures++;
      $display("FAIL reset_outputs1 rdy=%0b we=%0b addr=%h data=%h busy=%0b done=%0b err=%0b required all 0",
               in_ready1, mem_we1, mem_addr1, mem_wdata1, busy1, done1, err1);
    end
    checks++;
    if (st0 !== S_IDLE) begin
      failures++;
      $display("FAIL reset_state state=%0d required IDLE", st0);
    end
  endtask

  task automatic test_two_words();
    int w0;
    data_b = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    model_push(2);
    w0 = nwr;
    load(2, 0, model_xor());
    checks++;
    if (nwr - w0 !== 2 || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL two_words_count writes=%0d left=%0d required 2 and 0", nwr - w0, exp_q.size());
    end
    checks++;
    if (done0 !== 1 || err0 !== 0 || busy0 !== 0 || done1 !== 1 || err1 !== 0) begin
      failures++;
      $display("FAIL two_words_status done=%0b err=%0b busy=%0b required 1 0 0", done0, err0, busy0);
    end
    checks++;
    if (mem_addr1 !== 32'd17 || mem_wdata1 !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL two_words_hold addr1=%0d data1=%h required 17 deadbeef", mem_addr1, mem_wdata1);
    end
  endtask

  task automatic test_base_offset();
    int w0;
    data_b = '{8'h7F, 8'h00, 8'h00, 8'h00};
    model_push(1);
    w0 = nwr;
    load(1, 1, model_xor());
    checks++;
    if (nwr - w0 !== 1 || mem_addr1 !== 32'd16 || mem_wdata1 !== 32'h0000007F) begin
      failures++;
      $display("FAIL base_offset writes=%0d addr1=%0d data1=%h required 1 16 0000007f",
               nwr - w0, mem_addr1, mem_wdata1);
    end
  endtask

  task automatic test_zero_count();
    int w0;
    data_b.delete();
    w0 = nwr;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    in_valid = 1'b0;
    checks++;
    if (done0 !== 1 || err0 !== 0 || busy0 !== 0 || nwr != w0) begin
      failures++;
      $display("FAIL zero_count done=%0b err=%0b busy=%0b writes=%0d required 1 0 0 0",
               done0, err0, busy0, nwr - w0);
    end
  endtask

  task automatic test_too_many();
    int w0;
    data_b.delete();
    w0 = nwr;
    pulse_start();
    checks++;
    if (busy0 !== 1 || done0 !== 0) begin
      failures++;
      $display("FAIL start_status busy=%0b done=%0b required 1 0", busy0, done0);
    end
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    in_valid = 1'b0;
    checks++;
    if (done0 !== 1 || err0 !== 1 || err1 !== 1 || nwr != w0) begin
      failures++;
      $display("FAIL too_many done=%0b err=%0b writes=%0d required 1 1 0", done0, err0, nwr - w0);
    end
    repeat (3) @(posedge clk); #1;
    checks++;
    if (done0 !== 1 || err0 !== 1 || in_ready0 !== 0) begin
      failures++;
      $display("FAIL too_many_hold done=%0b err=%0b ready=%0b required 1 1 0", done0, err0, in_ready0);
    end
  endtask

  task automatic test_random();
    int unsigned cnt;
    int w0;
    for (int r = 0; r < 8; r++) begin
      cnt = $urandom_range(1, 6);
      data_b.delete();
      for (int k = 0; k < int'(cnt) * 4; k++) data_b.push_back(8'($urandom_range(0, 255)));
      model_push(cnt);
      w0 = nwr;
      load(cnt, (r == 0) ? 0 : 3, model_xor());
      checks++;
      if (nwr - w0 !== int'(cnt) || exp_q.size() !== 0 || done0 !== 1 || err0 !== 0) begin
        failures++;
        $display("FAIL random_load%0d writes=%0d left=%0d done=%0b err=%0b required %0d 0 1 0",
                 r, nwr - w0, exp_q.size(), done0, err0, cnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    data_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    exp_q.push_back(32'h44332211);
    exp_i.push_back(0);
    pulse_start();
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    foreach (data_b[k]) send_byte(data_b[k], 0);
    in_byte = 8'h77;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready0 !== 0 || mem_we0 !== 0 || mem_addr0 !== 0 || mem_wdata0 !== 0 ||
        busy0 !== 0 || done0 !== 0 || err0 !== 0 || mem_addr1 !== 0 || mem_wdata1 !== 0) begin
      failures++;
      $display("FAIL reset_mid_outputs rdy=%0b we=%0b addr=%h data=%h busy=%0b required all 0",
               in_ready0, mem_we0, mem_addr0, mem_wdata0, busy0);
    end
    w0 = nwr;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (nwr != w0 || exp_q.size() !== 0 || busy0 !== 0 || done0 !== 0 || in_ready0 !== 0) begin
      failures++;
      $display("FAIL reset_mid_after writes=%0d left=%0d busy=%0b done=%0b required 0 0 0 0",
               nwr - w0, exp_q.size(), busy0, done0);
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int w0;
    data_b = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    model_push(2);
    load(2, 1, model_xor());
    checks++;
    if (done0 !== 1 || err0 !== 0) begin
      failures++;
      $display("FAIL checksum_good done=%0b err=%0b required 1 0", done0, err0);
    end
    model_push(2);
    w0 = nwr;
    load(2, 1, 8'h00);
    checks++;
    if (done0 !== 1 || err0 !== 1 || nwr - w0 !== 2 || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL checksum_bad done=%0b err=%0b writes=%0d required 1 1 2", done0, err0, nwr - w0);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_two_words();
    test_base_offset();
    test_zero_count();
    test_too_many();
    test_random();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
